// File: rtl/airi5c_fetch_align.sv
// airi5c_fetch_align
// Instruction fetch front end. Issues word-aligned requests on the
// instruction memory port, buffers the returned halfwords and hands one
// aligned 16- or 32-bit instruction per handshake to decode. Instructions
// that straddle a word boundary are reassembled from two responses.
//
// Ports
//   clk_i, rst_ni          clock (rising edge), async active-low reset
//   redirect_i/_pc_i       load a new fetch PC, flush buffer and in-flight data
//   imem_req_o/_addr_o     word-aligned request, held until imem_gnt_i
//   imem_gnt_i             request accepted this cycle
//   imem_rvalid_i/_rdata_i response (one per grant), little-endian halfwords
//   imem_err_i             bus error, qualified by imem_rvalid_i
//   inst_valid_o/_ready_i  handshake towards decode
//   inst_o, pc_o           instruction and its PC
//   compressed_o           inst_o is a 16-bit instruction
//   err_o                  fetch fault at pc_o
//
// Every output comes straight from a flop: the next buffer contents are
// computed combinationally and the presented instruction is decoded from
// them before being registered.
module airi5c_fetch_align #(
  parameter int unsigned        XPR_LEN  = 32,
  parameter logic [XPR_LEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               redirect_i,
  input  logic [XPR_LEN-1:0] redirect_pc_i,
  output logic               imem_req_o,
  output logic [XPR_LEN-1:0] imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [31:0]        imem_rdata_i,
  input  logic               imem_err_i,
  output logic               inst_valid_o,
  input  logic               inst_ready_i,
  output logic [31:0]        inst_o,
  output logic [XPR_LEN-1:0] pc_o,
  output logic               compressed_o,
  output logic               err_o
);

  typedef enum logic [1:0] {
    S_REQ,
    S_RSP,
    S_DROP,
    S_HALT
  } state_t;

  localparam logic [XPR_LEN-1:0] HALF_MASK = {{(XPR_LEN-1){1'b1}}, 1'b0};
  localparam logic [XPR_LEN-1:0] WORD_MASK = {{(XPR_LEN-2){1'b1}}, 2'b00};
  localparam logic [XPR_LEN-1:0] STEP2     = XPR_LEN'(2);
  localparam logic [XPR_LEN-1:0] STEP4     = XPR_LEN'(4);

  state_t               state_q, state_n;
  logic [1:0]           count_q, count_n;
  logic [15:0]          slot_q [3];
  logic [15:0]          slot_n [3];
  logic [2:0]           serr_q, serr_n;
  logic [XPR_LEN-1:0]   fetch_addr_q, fetch_addr_n;
  logic                 skip_lo_q, skip_lo_n;
  logic [XPR_LEN-1:0]   pc_n;

  logic                 fire;
  logic                 grant;
  logic                 rsp_accept;
  logic [1:0]           pop_cnt;
  logic [1:0]           push_cnt;
  logic [1:0]           rem;
  logic                 req_n;
  logic                 valid_n;
  logic [31:0]          inst_n;
  logic                 comp_n;
  logic                 err_n;

  // A handshake coinciding with a redirect is discarded. Only responses
  // to requests issued since the last redirect are ever accepted.
  assign fire       = inst_valid_o & inst_ready_i & ~redirect_i;
  assign grant      = imem_req_o & imem_gnt_i;
  assign rsp_accept = (state_q == S_RSP) & imem_rvalid_i & ~redirect_i;

  // An error entry drains the whole buffer; otherwise pop one or two slots.
  always_comb begin
    pop_cnt = 2'd0;
    if (fire) begin
      if (err_o)             pop_cnt = count_q;
      else if (compressed_o) pop_cnt = 2'd1;
      else                   pop_cnt = 2'd2;
    end
    push_cnt = 2'd0;
    if (rsp_accept) push_cnt = skip_lo_q ? 2'd1 : 2'd2;
  end

  assign rem = count_q - pop_cnt;

  // Shift out popped halfwords, then append the response behind what is
  // left. Requests only go out at count <= 1, so rem + push never exceeds 3.
  always_comb begin
    slot_n = slot_q;
    serr_n = serr_q;
    case (pop_cnt)
      2'd1: begin
        slot_n[0] = slot_q[1];
        slot_n[1] = slot_q[2];
        serr_n[0] = serr_q[1];
        serr_n[1] = serr_q[2];
      end
      2'd2: begin
        slot_n[0] = slot_q[2];
        serr_n[0] = serr_q[2];
      end
      default: ;
    endcase
    if (rsp_accept) begin
      for (int i = 0; i < 3; i++) begin
        if (2'(i) == rem) begin
          slot_n[i] = skip_lo_q ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
          serr_n[i] = imem_err_i;
        end else if (!skip_lo_q && (2'(i) == rem + 2'd1)) begin
          slot_n[i] = imem_rdata_i[31:16];
          serr_n[i] = imem_err_i;
        end
      end
    end
    count_n = redirect_i ? 2'd0 : rem + push_cnt;
  end

  // Request FSM and fetch address. A redirect overrides the +4 advance of
  // a grant in the same cycle; that grant's response is then dropped.
  always_comb begin
    state_n      = state_q;
    fetch_addr_n = fetch_addr_q;
    if (grant) fetch_addr_n = fetch_addr_q + STEP4;
    case (state_q)
      S_REQ: begin
        if (redirect_i)  state_n = grant ? S_DROP : S_REQ;
        else if (grant)  state_n = S_RSP;
      end
      S_RSP: begin
        if (redirect_i)         state_n = imem_rvalid_i ? S_REQ : S_DROP;
        else if (imem_rvalid_i) state_n = imem_err_i ? S_HALT : S_REQ;
      end
      S_DROP: begin
        if (imem_rvalid_i) state_n = S_REQ;
      end
      default: begin
        if (redirect_i) state_n = S_REQ;
      end
    endcase
    if (redirect_i) fetch_addr_n = redirect_pc_i & WORD_MASK;

    if (redirect_i)      skip_lo_n = redirect_pc_i[1];
    else if (rsp_accept) skip_lo_n = 1'b0;
    else                 skip_lo_n = skip_lo_q;

    req_n = (state_n == S_REQ) && (count_n <= 2'd1);

    if (redirect_i)                 pc_n = redirect_pc_i & HALF_MASK;
    else if (fire && !compressed_o && !err_o) pc_n = pc_o + STEP4;
    else if (fire)                  pc_n = pc_o + STEP2;
    else                            pc_n = pc_o;
  end

  // Decode the instruction that will sit at the head of the buffer next
  // cycle. A flagged slot 0, or a flagged slot 1 of a 32-bit instruction,
  // is presented as a fault with zeroed instruction bits.
  always_comb begin
    valid_n = 1'b0;
    inst_n  = 32'h0;
    comp_n  = 1'b0;
    err_n   = 1'b0;
    if (count_n != 2'd0) begin
      if (serr_n[0]) begin
        valid_n = 1'b1;
        err_n   = 1'b1;
      end else if (slot_n[0][1:0] != 2'b11) begin
        valid_n = 1'b1;
        comp_n  = 1'b1;
        inst_n  = {16'h0, slot_n[0]};
      end else if (count_n >= 2'd2) begin
        valid_n = 1'b1;
        if (serr_n[1]) err_n  = 1'b1;
        else           inst_n = {slot_n[1], slot_n[0]};
      end
    end
  end

  // State, buffer and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_REQ;
      count_q      <= 2'd0;
      for (int i = 0; i < 3; i++) slot_q[i] <= 16'h0;
      serr_q       <= 3'b000;
      fetch_addr_q <= RESET_PC & WORD_MASK;
      skip_lo_q    <= RESET_PC[1];
      imem_req_o   <= 1'b0;
      imem_addr_o  <= '0;
      inst_valid_o <= 1'b0;
      inst_o       <= 32'h0;
      pc_o         <= RESET_PC & HALF_MASK;
      compressed_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_n;
      count_q      <= count_n;
      slot_q       <= slot_n;
      serr_q       <= serr_n;
      fetch_addr_q <= fetch_addr_n;
      skip_lo_q    <= skip_lo_n;
      imem_req_o   <= req_n;
      imem_addr_o  <= fetch_addr_n;
      inst_valid_o <= valid_n;
      inst_o       <= inst_n;
      pc_o         <= pc_n;
      compressed_o <= comp_n;
      err_o        <= err_n;
    end
  end

endmodule

// File: tb/tb_airi5c_fetch_align.sv
module tb_airi5c_fetch_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b1;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        compressed;
  logic        err;

  int passed = 0;
  int total  = 0;

  // memory model state
  int          lat = 1;
  logic        pend = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] glog [256];
  int          gcount = 0;

  airi5c_fetch_align dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .imem_err_i    (imem_err),
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (inst_ready),
    .inst_o        (inst),
    .pc_o          (pc),
    .compressed_o  (compressed),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    case (a)
      32'h8000_0000: memWord = 32'h0041_0113;
      32'h0000_0100: memWord = 32'h4501_0001;
      32'h0000_0200: memWord = 32'h0513_0001;
      32'h0000_0204: memWord = 32'h1234_0000;
      32'h0000_02FC: memWord = 32'h0513_0000;
      32'h0000_0300: memWord = 32'hDEAD_BEEF;
      32'h0000_0400: memWord = 32'h0505_AAAA;
      32'h0000_0404: memWord = 32'h0809_0709;
      32'h0000_0500: memWord = 32'h0002_0413;
      32'h0000_0504: memWord = 32'h0001_4485;
      32'h0000_0600: memWord = 32'h0001_4501;
      32'h0000_0700: memWord = 32'h7777_7777;
      32'hFFFF_FFFC: memWord = 32'h2222_0001;
      32'h0000_0000: memWord = 32'h3333_1111;
      default:       memWord = 32'h0001_0001;
    endcase
  endfunction

  // Memory: grants immediately, answers 'lat' cycles after the grant,
  // signals a bus error for address 0x300.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_err    = 1'b0;
    imem_gnt    = 1'b0;
    if (pend) begin
      if (wait_cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memWord(paddr);
        imem_err    = (paddr == 32'h0000_0300);
        pend        = 1'b0;
      end else begin
        wait_cnt = wait_cnt - 1;
      end
    end
    if (imem_req && !pend) begin
      imem_gnt = 1'b1;
      pend     = 1'b1;
      paddr    = imem_addr;
      wait_cnt = lat;
      if (gcount < 256) glog[gcount] = imem_addr;
      gcount   = gcount + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic applyRedirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    @(posedge clk);
    #1;
    redirect    = 1'b0;
  endtask

  // Wait (bounded) for a valid instruction, compare it, then step past the
  // handshake cycle.
  task automatic waitInst(input string name, input logic [31:0] e_inst, input logic [31:0] e_pc,
                          input logic e_comp, input logic e_err, output int waited);
    int n = 0;
    while (inst_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (inst_valid !== 1'b1) begin
      total = total + 1;
      $display("[TB] FAIL %s_timeout: inst_valid got %b expected 1", name, inst_valid);
    end else begin
      checkOutput({name, "_inst"}, inst, e_inst);
      checkOutput({name, "_pc"}, pc, e_pc);
      checkOutput({name, "_comp"}, {31'h0, compressed}, {31'h0, e_comp});
      checkOutput({name, "_err"}, {31'h0, err}, {31'h0, e_err});
    end
    @(negedge clk);
  endtask

  task automatic observeIdle(input string name);
    logic any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (imem_req || inst_valid) any = 1'b1;
    end
    checkOutput(name, {31'h0, any}, 32'h0);
  endtask

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
    logic        err;
    int          lat;
    logic        halt_chk;
  } vec_t;

  vec_t vecs [13];

  task automatic applyStimulus();
    int n;
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].redir) applyRedirect(vecs[i].rpc);
      waitInst($sformatf("v%0d", i), vecs[i].inst, vecs[i].pc, vecs[i].comp, vecs[i].err, n);
      if (vecs[i].lat != 0) checkOutput($sformatf("v%0d_latency", i), n, vecs[i].lat);
      if (vecs[i].halt_chk) observeIdle($sformatf("v%0d_halted", i));
    end
  endtask

  initial begin
    int   n;
    int   mark;
    logic any;

    vecs[0]  = '{1'b0, 32'h0,         32'h0041_0113, 32'h8000_0000, 1'b0, 1'b0, 0, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0000_0100, 1'b1, 1'b0, 0, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,         32'h0000_4501, 32'h0000_0102, 1'b1, 1'b0, 0, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0202, 32'h0000_0513, 32'h0000_0202, 1'b0, 1'b0, 0, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0500, 32'h0002_0413, 32'h0000_0500, 1'b0, 1'b0, 0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,         32'h0000_4485, 32'h0000_0504, 1'b1, 1'b0, 0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,         32'h0000_0001, 32'h0000_0506, 1'b1, 1'b0, 0, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0300, 32'h0000_0000, 32'h0000_0300, 1'b0, 1'b1, 0, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_02FE, 32'h0000_0000, 32'h0000_02FE, 1'b0, 1'b1, 0, 1'b1};
    vecs[9]  = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0001, 32'hFFFF_FFFC, 1'b1, 1'b0, 3, 1'b0};
    vecs[10] = '{1'b0, 32'h0,         32'h0000_2222, 32'hFFFF_FFFE, 1'b1, 1'b0, 0, 1'b0};
    vecs[11] = '{1'b0, 32'h0,         32'h0000_1111, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0};
    vecs[12] = '{1'b0, 32'h0,         32'h0001_3333, 32'h0000_0002, 1'b0, 1'b0, 0, 1'b0};

    // reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_req",   {31'h0, imem_req},   32'h0);
    checkOutput("rst_addr",  imem_addr,           32'h0);
    checkOutput("rst_valid", {31'h0, inst_valid}, 32'h0);
    checkOutput("rst_inst",  inst,                32'h0);
    checkOutput("rst_pc",    pc,                  32'h8000_0000);
    checkOutput("rst_comp",  {31'h0, compressed}, 32'h0);
    checkOutput("rst_err",   {31'h0, err},        32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_req",  {31'h0, imem_req}, 32'h1);
    checkOutput("first_addr", imem_addr,         32'h8000_0000);

    applyStimulus();

    if (gcount >= 2) checkOutput("second_req_addr", glog[1], 32'h8000_0004);
    else begin
      total = total + 1;
      $display("[TB] FAIL second_req_addr: got %0d grants expected at least 2", gcount);
    end

    // back-pressure: buffer fills to three halfwords, requests stop
    inst_ready = 1'b0;
    applyRedirect(32'h0000_0402);
    repeat (5) @(negedge clk);
    any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (imem_req) any = 1'b1;
    end
    checkOutput("stall_no_req", {31'h0, any}, 32'h0);
    inst_ready = 1'b1;
    waitInst("stall0", 32'h0000_0505, 32'h0000_0402, 1'b1, 1'b0, n);
    waitInst("stall1", 32'h0000_0709, 32'h0000_0404, 1'b1, 1'b0, n);
    waitInst("stall2", 32'h0000_0809, 32'h0000_0406, 1'b1, 1'b0, n);

    // redirect while a slow response is outstanding: stale data is dropped
    inst_ready = 1'b0;
    repeat (8) @(negedge clk);
    lat = 3;
    applyRedirect(32'h0000_0700);
    @(negedge clk);
    @(negedge clk);
    applyRedirect(32'h0000_0600);
    mark = gcount;
    inst_ready = 1'b1;
    waitInst("drop0", 32'h0000_4501, 32'h0000_0600, 1'b1, 1'b0, n);
    waitInst("drop1", 32'h0000_0001, 32'h0000_0602, 1'b1, 1'b0, n);
    if (gcount > mark && mark < 256) checkOutput("drop_req_addr", glog[mark], 32'h0000_0600);
    else begin
      total = total + 1;
      $display("[TB] FAIL drop_req_addr: got no grant after redirect expected one");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
